// File: rtl/music_box_state_play_recording.sv
// Music box playback state: reads recorded samples back in order at SAMPLE_HZ and strobes them on audioOut.
// Optional build macro MUSICBOX_PLAYBACK_LOOP_EN makes playback loop endlessly instead of finishing once.
module music_box_state_play_recording #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SAMPLE_HZ   = 1000,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 16,
    parameter int MAX_SAMPLES = 5000,
    parameter int PLAY_STATE  = 5
) (
    input  logic              clock_50Mhz,
    input  logic              reset_n,
    input  logic [4:0]        currentState,
    input  logic [15:0]       recordedLength,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] audioOut,
    output logic              audioValid,
    output logic              stateComplete,
    output logic [31:0]       debugString
);

    localparam int          TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int          PRE_W    = $clog2(TICK_DIV);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_SAMPLES);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, HOLD, DONE} state_t;

    state_t           state, state_next;
    logic [PRE_W-1:0] prescaler;
    logic [15:0]      eff_len;
    logic [15:0]      sample_index;
    logic [15:0]      loop_count;

    logic        in_play;
    logic        tick;
    logic        last_sample;
    logic        exiting;
    logic [15:0] len_clamped;

    assign in_play     = (currentState == 5'(PLAY_STATE));
    assign tick        = (prescaler == PRE_W'(TICK_DIV - 1));
    assign last_sample = (sample_index == eff_len - 16'd1);
    assign exiting     = (state != IDLE) && !in_play;
    assign len_clamped = (recordedLength > MAX_LEN) ? MAX_LEN : recordedLength;

    assign mem_read_addr = sample_index[ADDR_W-1:0];
    assign debugString   = {loop_count, sample_index};

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next    = state;
        mem_read_en   = 1'b0;
        stateComplete = 1'b0;
        unique case (state)
            IDLE:    if (in_play) state_next = (len_clamped == 16'd0) ? DONE : FETCH;
            FETCH: begin
                mem_read_en = 1'b1;
                state_next  = CAPTURE;
            end
`ifdef MUSICBOX_PLAYBACK_LOOP_EN
            CAPTURE: state_next = HOLD;
`else
            CAPTURE: state_next = last_sample ? DONE : HOLD;
`endif
            HOLD:    if (tick) state_next = FETCH;
            DONE:    stateComplete = 1'b1;
            default: state_next = IDLE;
        endcase
        // Leaving the play state overrides everything, including a read still in flight.
        if (exiting) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            prescaler    <= '0;
            eff_len      <= '0;
            sample_index <= '0;
            loop_count   <= '0;
            audioOut     <= '0;
            audioValid   <= 1'b0;
        end else begin
            audioValid <= 1'b0;
            if (exiting) begin
                prescaler    <= '0;
                sample_index <= '0;
                loop_count   <= '0;
                audioOut     <= '0;
            end else if (state == IDLE) begin
                if (in_play) begin
                    eff_len      <= len_clamped;
                    prescaler    <= '0;
                    sample_index <= '0;
                    loop_count   <= '0;
                end
            end else begin
                // Free-running from entry so strobes land exactly TICK_DIV cycles apart.
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (state == CAPTURE) begin
                    audioOut   <= mem_read_data;
                    audioValid <= 1'b1;
                    if (!last_sample) begin
                        sample_index <= sample_index + 16'd1;
                    end else begin
`ifdef MUSICBOX_PLAYBACK_LOOP_EN
                        sample_index <= '0;
                        loop_count   <= loop_count + 16'd1;
`endif
                    end
                end
            end
        end
    end

endmodule
